power_seq_ctrl: RTL and testbench

- Responder for the power on/off command pulses produced by the push-button power toggle logic.
- Consumes one-cycle on/off request pulses and sequences N supply-rail enables up in ascending order and down in descending order.
- Checks each rail's power-good (PG) input before enabling the next rail.
- Reports pwr_ok, busy and a latched fault to the rest of the SoC.

---
 rtl/power_seq_pkg.sv | 28 ++
 rtl/power_seq_step_timer.sv | 29 ++
 rtl/power_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_power_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_seq_pkg.sv
// Shared types and constants for the rail power sequencer.
// The PG handshake is compiled in only when POWER_SEQ_PG_CHECK_EN is defined.
package power_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_PG   = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_ON        = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // Defaults assume a 50 MHz clock: 1 ms per rail step, 10 ms PG timeout.
  localparam int DEF_STEP_CYC   = 50_000;
  localparam int DEF_PG_TIMEOUT = 500_000;
  localparam int DEF_CNT_W      = 20;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_busy(input state_e s);
    return s inside {ST_WAIT_PG, ST_SETTLE, ST_RAMP_DOWN};
  endfunction

endpackage

// File: rtl/power_seq_step_timer.sv
// Step/timeout counter: synchronous clear, count enable, saturates instead of
// wrapping, and flags when the count equals the supplied terminal value.
module power_seq_step_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/power_seq_ctrl.sv
// Sequences N supply rails up in ascending and down in descending order.
// Define POWER_SEQ_PG_CHECK_EN to add the PG handshake, timeout and PG-loss fault.
module power_seq_ctrl
  import power_seq_pkg::*;
#(
  parameter int N_RAILS    = 3,
  parameter int STEP_CYC   = DEF_STEP_CYC,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on_req,
  input  logic               off_req,
  input  logic [N_RAILS-1:0] pg_in,
  output logic [N_RAILS-1:0] rail_en,
  output logic               pwr_ok,
  output logic               busy,
  output logic               fault
);

  localparam int IDX_W = idx_width(N_RAILS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RAILS - 1);

`ifdef POWER_SEQ_PG_CHECK_EN
  localparam bit PG_CHECK = 1'b1;
`else
  localparam bit PG_CHECK = 1'b0;
`endif

  // Without the handshake a freshly enabled rail goes straight to its settle time.
  localparam state_e ENTRY_ST = PG_CHECK ? ST_WAIT_PG : ST_SETTLE;

  state_e             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_inc, idx_dec;
  logic [N_RAILS-1:0] pg_mask;
  logic               pg_lost, pg_here;
  logic               rail_up, rail_dn;
  logic               cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0]   term;

  assign idx_inc = idx + IDX_W'(1);
  assign idx_dec = idx - IDX_W'(1);
  assign pg_here = pg_in[idx];
  // A rail that has already reported good must stay good while sequencing or on.
  assign pg_lost = PG_CHECK && ((pg_in & pg_mask) != pg_mask);

  assign term = (state == ST_WAIT_PG) ? CNT_W'(PG_TIMEOUT - 1) : CNT_W'(STEP_CYC - 1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    rail_up   = 1'b0;
    rail_dn   = 1'b0;
    case (state)
      ST_OFF: begin
        if (on_req && !off_req) state_nxt = ENTRY_ST;
      end
      ST_WAIT_PG: begin
        if (pg_lost)      state_nxt = ST_FAULT;
        else if (off_req) state_nxt = ST_RAMP_DOWN;
        else if (pg_here) state_nxt = ST_SETTLE;
        else if (tc)      state_nxt = ST_FAULT;
      end
      ST_SETTLE: begin
        if (pg_lost) begin
          state_nxt = ST_FAULT;
        end else if (off_req) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (tc) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_ON;
          end else begin
            rail_up   = 1'b1;
            state_nxt = ENTRY_ST;
          end
        end
      end
      ST_ON: begin
        if (pg_lost)      state_nxt = ST_FAULT;
        else if (off_req) state_nxt = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (tc) begin
          if (idx == '0) state_nxt = ST_OFF;
          else           rail_dn   = 1'b1;
        end
      end
      ST_FAULT: begin
        if (off_req) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // The counter restarts on every state change and every rail step, and idles at 0.
  assign cnt_en  = is_busy(state);
  assign cnt_clr = (state_nxt != state) || rail_up || rail_dn || !cnt_en;

  power_seq_step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (term),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_OFF;
      idx     <= '0;
      rail_en <= '0;
      pg_mask <= '0;
      pwr_ok  <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwr_ok <= (state_nxt == ST_ON);
      busy   <= is_busy(state_nxt);
      fault  <= PG_CHECK && (state_nxt == ST_FAULT);

      if ((state_nxt == ST_FAULT) && (state != ST_FAULT)) begin
        // All rails drop together on a fault, not in sequence.
        rail_en <= '0;
        pg_mask <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            if (state_nxt != ST_OFF) begin
              idx     <= '0;
              rail_en <= N_RAILS'(1);
            end
          end
          ST_WAIT_PG: begin
            if (state_nxt == ST_SETTLE) begin
              pg_mask[idx] <= 1'b1;
            end else if (state_nxt == ST_RAMP_DOWN) begin
              rail_en[idx] <= 1'b0;
              pg_mask[idx] <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (rail_up) begin
              idx              <= idx_inc;
              rail_en[idx_inc] <= 1'b1;
            end else if (state_nxt == ST_RAMP_DOWN) begin
              rail_en[idx] <= 1'b0;
              pg_mask[idx] <= 1'b0;
            end
          end
          ST_ON: begin
            if (state_nxt == ST_RAMP_DOWN) begin
              idx               <= LAST_IDX;
              rail_en[LAST_IDX] <= 1'b0;
              pg_mask[LAST_IDX] <= 1'b0;
            end
          end
          ST_RAMP_DOWN: begin
            if (rail_dn) begin
              idx              <= idx_dec;
              rail_en[idx_dec] <= 1'b0;
              pg_mask[idx_dec] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_power_seq_ctrl.sv
// Directed bench for power_seq_ctrl (N_RAILS=3, STEP_CYC=4, PG_TIMEOUT=16);
// pg_in models each rail reporting good two cycles after its enable.
module tb_power_seq_ctrl;

  localparam int N = 3;

`ifdef POWER_SEQ_PG_CHECK_EN
  localparam int T_R1 = 7, T_R2 = 14, T_ON = 21, T_SET1 = 10, T_MID = 10;
`else
  localparam int T_R1 = 4, T_R2 = 8, T_ON = 12, T_SET1 = 4, T_MID = 6;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         on_req = 1'b0, off_req = 1'b0;
  logic [N-1:0] pg_in, rail_en;
  logic [N-1:0] pg_kill = '0, pg_d1 = '0, pg_d2 = '0;
  logic         pwr_ok, busy, fault;
  int           n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pg_d1 <= rail_en;
    pg_d2 <= pg_d1;
  end
  assign pg_in = pg_d2 & ~pg_kill;

  power_seq_ctrl #(
    .N_RAILS    (N),
    .STEP_CYC   (4),
    .PG_TIMEOUT (16),
    .CNT_W      (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .on_req  (on_req),
    .off_req (off_req),
    .pg_in   (pg_in),
    .rail_en (rail_en),
    .pwr_ok  (pwr_ok),
    .busy    (busy),
    .fault   (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic on, input logic off);
    on_req  = on;
    off_req = off;
    tick();
    on_req  = 1'b0;
    off_req = 1'b0;
  endtask

  // Expected vectors below are {rail_en, busy, pwr_ok, fault}.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL reset_state got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    rst_n = 1'b1;
    pulse(1'b0, 1'b1);
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL off_in_off got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    pulse(1'b1, 1'b1);
    tick();
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL both_in_off got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
  endtask

  task automatic test_power_up();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    for (int k = 0; k <= T_ON; k++) begin
      exp[5:3] = (k < T_R1) ? 3'b001 : (k < T_R2) ? 3'b011 : 3'b111;
      exp[2]   = (k < T_ON);
      exp[1]   = (k >= T_ON);
      exp[0]   = 1'b0;
      n_cmp++;
      if ({rail_en, busy, pwr_ok, fault} !== exp) begin
        n_bad++;
        $display("FAIL power_up edge %0d got=%b want=%b", k, {rail_en, busy, pwr_ok, fault}, exp);
      end
      if (k < T_ON) tick();
    end
  endtask

  task automatic test_power_down();
    logic [5:0] exp;
    pulse(1'b0, 1'b1);
    for (int k = 0; k <= 12; k++) begin
      exp[5:3] = (k < 4) ? 3'b011 : (k < 8) ? 3'b001 : 3'b000;
      exp[2]   = (k < 12);
      exp[1:0] = 2'b00;
      n_cmp++;
      if ({rail_en, busy, pwr_ok, fault} !== exp) begin
        n_bad++;
        $display("FAIL power_down edge %0d got=%b want=%b", k, {rail_en, busy, pwr_ok, fault}, exp);
      end
      if (k < 12) tick();
    end
  endtask

`ifdef POWER_SEQ_PG_CHECK_EN
  task automatic test_pg_timeout();
    logic [5:0] exp;
    pg_kill = 3'b010;
    pulse(1'b1, 1'b0);
    for (int k = 0; k <= 23; k++) begin
      exp[5:3] = (k < 7) ? 3'b001 : (k < 23) ? 3'b011 : 3'b000;
      exp[2]   = (k < 23);
      exp[1]   = 1'b0;
      exp[0]   = (k == 23);
      n_cmp++;
      if ({rail_en, busy, pwr_ok, fault} !== exp) begin
        n_bad++;
        $display("FAIL pg_timeout edge %0d got=%b want=%b", k, {rail_en, busy, pwr_ok, fault}, exp);
      end
      if (k < 23) tick();
    end
    pulse(1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_001) begin
      n_bad++;
      $display("FAIL on_in_fault got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_001);
    end
    pulse(1'b0, 1'b1);
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL fault_exit got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    pg_kill = '0;
    repeat (3) tick();
  endtask

  task automatic test_pg_loss();
    test_power_up();
    pg_kill = 3'b001;
    tick();
    pg_kill = '0;
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_001) begin
      n_bad++;
      $display("FAIL pg_loss got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_001);
    end
    pulse(1'b0, 1'b1);
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL pg_loss_exit got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    repeat (3) tick();
  endtask
`else
  task automatic test_pg_ignored();
    pg_kill = '1;
    test_power_up();
    test_power_down();
    pg_kill = '0;
  endtask
`endif

  task automatic test_abort();
    logic [5:0] exp;
    pulse(1'b1, 1'b0);
    repeat (T_SET1) tick();
    n_cmp++;
    if (rail_en !== 3'b011) begin
      n_bad++;
      $display("FAIL abort_pre rail_en=%b want=%b", rail_en, 3'b011);
    end
    pulse(1'b0, 1'b1);
    for (int k = 0; k <= 8; k++) begin
      exp[5:3] = (k < 4) ? 3'b001 : 3'b000;
      exp[2]   = (k < 8);
      exp[1:0] = 2'b00;
      n_cmp++;
      if ({rail_en, busy, pwr_ok, fault} !== exp) begin
        n_bad++;
        $display("FAIL abort edge %0d got=%b want=%b", k, {rail_en, busy, pwr_ok, fault}, exp);
      end
      if (k < 8) tick();
    end
  endtask

  // Both requests while ON start a ramp-down; an on_req mid-ramp is dropped.
  task automatic test_conflict();
    logic [5:0] exp;
    test_power_up();
    pulse(1'b1, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      exp[5:3] = (k < 4) ? 3'b011 : (k < 8) ? 3'b001 : 3'b000;
      exp[2]   = (k < 12);
      exp[1:0] = 2'b00;
      n_cmp++;
      if ({rail_en, busy, pwr_ok, fault} !== exp) begin
        n_bad++;
        $display("FAIL conflict edge %0d got=%b want=%b", k, {rail_en, busy, pwr_ok, fault}, exp);
      end
      on_req = (k == 1);
      tick();
    end
    on_req = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0);
    repeat (T_MID) tick();
    n_cmp++;
    if ({rail_en, busy} !== 4'b011_1) begin
      n_bad++;
      $display("FAIL mid_seq got=%b want=%b", {rail_en, busy}, 4'b011_1);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL async_reset got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    #2 rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({rail_en, busy, pwr_ok, fault} !== 6'b000_000) begin
      n_bad++;
      $display("FAIL post_reset got=%b want=%b", {rail_en, busy, pwr_ok, fault}, 6'b000_000);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
`ifdef POWER_SEQ_PG_CHECK_EN
    test_pg_timeout();
    test_pg_loss();
`else
    test_pg_ignored();
`endif
    test_abort();
    test_conflict();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
